code_loader: RTL
================

CODE_LOADER -- requirements
Module: code_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of first code word written.
REQ-002 SHALL have parameter MAX_WORDS, default 4096, largest accepted image length in 32-bit words.
REQ-003 SHALL have reset rst_n, asynchronous, active-low; clock clk.
REQ-004 SHALL have port clk  input  1  system clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle pulse to begin a load; ignored unless state is IDLE, DONE or ERROR.
REQ-007 SHALL have port rx_valid  input  1  upstream byte valid.
REQ-008 SHALL have port rx_data  input  8  upstream byte.
REQ-009 SHALL have port rx_ready  output  1  byte accepted when rx_valid && rx_ready.
REQ-010 SHALL have port data_bus  ibex_data_bus.master  -  write master into code RAM (req, addr, we, be, wdata out; gnt, rvalid, err in).
REQ-011 SHALL have port busy  output  1  load in progress.
REQ-012 SHALL have port done  output  1  image fully written, held until next start.
REQ-013 SHALL have port error  output  1  load aborted, held until next start.
REQ-014 SHALL have port fetch_enable  output  1  core may fetch; equals done.

Function
REQ-015 SHALL implement FSM states IDLE, LEN, DATA, WRITE, RESP, DONE, ERROR.
REQ-016 SHALL move from IDLE, DONE or ERROR to LEN on start, clearing done, error, byte counter and word index.
REQ-017 SHALL assert rx_ready only in LEN and DATA; all other states SHALL hold rx_ready low.
REQ-018 SHALL, in LEN, assemble 4 bytes little-endian into a 32-bit length L.
REQ-019 SHALL, after the 4th length byte, go to DONE if L==0, to ERROR if L>MAX_WORDS, otherwise to DATA.
REQ-020 SHALL, in DATA, assemble 4 bytes little-endian (first byte -> wdata[7:0]) and go to WRITE the cycle after the 4th byte.
REQ-021 SHALL, in WRITE, drive req=1, we=1, be=4'hF, addr=BASE_ADDR+4*idx, and stable wdata until gnt is sampled high.
REQ-022 SHALL deassert req the cycle after gnt and enter RESP.
REQ-023 SHALL, in RESP on rvalid: if err go to ERROR; else increment idx and go to DONE if idx+1==L, otherwise to DATA.
REQ-024 SHALL compute addr in 32-bit arithmetic with wrap-around and no overflow check.
REQ-025 SHALL hold data_bus.wdata/addr/be at zero and we/req low outside WRITE.
REQ-026 SHALL assert busy in LEN, DATA, WRITE and RESP; done in DONE only; error in ERROR only.
REQ-027 SHALL ignore start while busy.
REQ-028 SHALL count bytes with a 2-bit counter that wraps after each word.
REQ-029 SHALL latency per word be 4 accepted bytes + 1 cycle to WRITE + gnt wait + 1 + rvalid wait.

Reset
REQ-030 SHALL on rst_n low enter IDLE asynchronously, with req, we, rx_ready, busy, done, error and fetch_enable at 0, addr, wdata and be at 0, and all counters cleared.
REQ-031 SHALL abandon any partial word or outstanding transfer on reset mid-load; the core stays halted until a new complete load.

Structure
REQ-032 SHALL place the state enum and the LEN_BYTES=4 and WORD_BYTES=4 constants in package code_loader_pkg.
REQ-033 SHALL use one sub-module, word_assembler, a 4-byte little-endian shift/pack register with byte count and word_valid output.

Verification
REQ-034 SHALL check stream 02 00 00 00, 13 00 00 00, 6F 00 00 00: writes 0x00000013 @BASE and 0x0000006F @BASE+4, then done=1 and fetch_enable=1.
REQ-035 SHALL check length bytes 00 00 00 00: done=1 without any req.
REQ-036 SHALL check L=MAX_WORDS+1: error=1, no req, rx_ready=0.
REQ-037 SHALL check gnt withheld 5 cycles: req, addr and wdata are stable for all 5 cycles, and rx_ready=0 throughout.
REQ-038 SHALL check rvalid with err=1 on word 0 of L=3: error=1, no further req.
REQ-039 SHALL check rst_n pulsed low during WRITE, then start with L=1 and word 0xDEADBEEF: a single write of 0xDEADBEEF @BASE, then done=1.

Source files
------------

// File: rtl/code_loader_pkg.sv
// Shared types and constants for the boot code loader.
package code_loader_pkg;

  localparam int LEN_BYTES  = 4;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } state_t;

  // Byte address of code word idx; 32-bit wrap-around is intentional.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + {idx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/ibex_data_bus.sv
// Simple request/grant data bus used to write the code RAM.
interface ibex_data_bus;
  logic        req;
  logic        gnt;
  logic        rvalid;
  logic        err;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, err);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, err);
endinterface

// File: rtl/code_loader_word_assembler.sv
// Packs a byte stream little-endian into 32-bit words (first byte -> [7:0]).
module word_assembler
  import code_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic [31:0] word_next,
  output logic        word_valid
);

  logic [1:0] byte_cnt;

  // Next value shifts the new byte in at the top so the first byte ends at [7:0].
  assign word_next  = {byte_data, word[31:8]};
  assign word_valid = byte_valid && (byte_cnt == 2'(WORD_BYTES - 1));

  // Shift register and wrapping 2-bit byte counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (clr) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (byte_valid) begin
      word     <= word_next;
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/code_loader.sv
// Streams a length-prefixed code image from a byte source into code RAM,
// then releases the core for fetch.
//
// state | meaning
// IDLE  | after reset, waiting for start
// LEN   | collecting the 4-byte little-endian word count
// DATA  | collecting the 4 bytes of the next code word
// WRITE | bus request held until granted
// RESP  | waiting for the write response
// DONE  | image written, fetch enabled
// ERROR | length out of range or bus error, core stays halted
module code_loader
  import code_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 rx_ready,
  ibex_data_bus.master         data_bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 fetch_enable
);

  state_t      state_q;
  logic [31:0] len_q;
  logic [31:0] idx_q;
  logic        start_ok;
  logic        byte_fire;
  logic [31:0] asm_word;
  logic [31:0] asm_word_next;
  logic        asm_word_valid;

  assign start_ok  = start && (state_q == IDLE || state_q == DONE || state_q == ERROR);
  assign rx_ready  = (state_q == LEN) || (state_q == DATA);
  assign byte_fire = rx_valid && rx_ready;

  word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start_ok),
    .byte_valid (byte_fire),
    .byte_data  (rx_data),
    .word       (asm_word),
    .word_next  (asm_word_next),
    .word_valid (asm_word_valid)
  );

  // Load sequencing: length header, then per-word collect / write / response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (start_ok) begin
            state_q <= LEN;
            len_q   <= '0;
            idx_q   <= '0;
          end
        end
        LEN: begin
          if (asm_word_valid) begin
            len_q <= asm_word_next;
            if (asm_word_next == 32'd0)                 state_q <= DONE;
            else if (asm_word_next > 32'(MAX_WORDS))    state_q <= ERROR;
            else                                        state_q <= DATA;
          end
        end
        DATA: begin
          if (asm_word_valid) state_q <= WRITE;
        end
        WRITE: begin
          if (data_bus.gnt) state_q <= RESP;
        end
        RESP: begin
          if (data_bus.rvalid) begin
            if (data_bus.err) begin
              state_q <= ERROR;
            end else begin
              idx_q <= idx_q + 32'd1;
              if (idx_q + 32'd1 == len_q) state_q <= DONE;
              else                        state_q <= DATA;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bus outputs are only non-zero while a write is being offered.
  always_comb begin
    data_bus.req   = 1'b0;
    data_bus.we    = 1'b0;
    data_bus.be    = 4'h0;
    data_bus.addr  = 32'h0;
    data_bus.wdata = 32'h0;
    if (state_q == WRITE) begin
      data_bus.req   = 1'b1;
      data_bus.we    = 1'b1;
      data_bus.be    = 4'hF;
      data_bus.addr  = word_addr(BASE_ADDR, idx_q);
      data_bus.wdata = asm_word;
    end
  end

  // Status decode.
  always_comb begin
    busy         = (state_q == LEN) || (state_q == DATA) || (state_q == WRITE) || (state_q == RESP);
    done         = (state_q == DONE);
    error        = (state_q == ERROR);
    fetch_enable = done;
  end

endmodule
